// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : arbitrates icache/dcache requests onto a single RAM port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam int            c_SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [1:0]    c_RAM_ACCESS = 2'd2;
  localparam logic [1:0]    c_RAM_ERROR  = 2'd3;
  localparam logic [c_SW-1:0] c_STREAK_MAX = c_SW'(MAX_DSTREAK);

  state_t          state_q, state_d;
  logic [c_SW-1:0] dstreak_q, dstreak_d;
  logic            ram_err_q, ram_err_d;

  logic w_dreq;
  logic w_i_done;
  logic w_d_done;

  assign w_dreq   = dREN | dWEN;
  // Completion only counts while the owner still requests; a dropped request is an abort.
  assign w_i_done = (state_q == IGNT) && iREN   && (ramstate == c_RAM_ACCESS);
  assign w_d_done = (state_q == DGNT) && w_dreq && (ramstate == c_RAM_ACCESS);

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    ram_err_d = ram_err_q | ((state_q != IDLE) && (ramstate == c_RAM_ERROR));
    case (state_q)
      IDLE: begin
        if (w_dreq && !(iREN && (dstreak_q == c_STREAK_MAX))) state_d = DGNT;
        else if (iREN)                                        state_d = IGNT;
      end
      IGNT: begin
        if (!iREN || w_i_done) state_d = IDLE;
        if (w_i_done)          dstreak_d = '0;
      end
      DGNT: begin
        if (!w_dreq || w_d_done) state_d = IDLE;
        if (w_d_done) begin
          if (!iREN)                           dstreak_d = '0;
          else if (dstreak_q != c_STREAK_MAX)  dstreak_d = dstreak_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      ram_err_q <= ram_err_d;
    end
  end

  // RAM side follows the owner's request combinationally so aborts drop enables at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state_q)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (w_i_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGNT: begin
        ramWEN  = dWEN;
        ramREN  = dREN & ~dWEN;
        ramaddr = daddr;
        if (dWEN) ramstore = dstore;
        if (w_d_done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      default: ;
    endcase
  end

  assign ram_err = ram_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter.
// Revision       : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ram_err;

  int checks;
  int errors;

  logic [1:0] st;
  logic [2:0] dst;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .ram_err  (ram_err)
  );

  assign st  = dut.state_q;
  assign dst = dut.dstreak_q;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
    #2 nRST = 1'b0;
    #3;
    checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'd0) begin
      errors++; $display("FAIL rst_ram got %0b %0b %h %h exp 0 0 0 0", ramREN, ramWEN, ramaddr, ramstore);
    end
    checks++;
    if ({iwait, dwait, iload, dload, ram_err} !== {1'b1, 1'b1, 64'd0, 1'b0}) begin
      errors++; $display("FAIL rst_cache got iw=%0b dw=%0b il=%h dl=%h err=%0b exp 1 1 0 0 0", iwait, dwait, iload, dload, ram_err);
    end
    checks++;
    if (st !== 2'd0 || dst !== 3'd0) begin
      errors++; $display("FAIL rst_state got st=%0d dst=%0d exp 0 0", st, dst);
    end
    @(negedge CLK) nRST = 1'b1;
    tick();
  endtask

  task automatic test_icache_read();
    iREN = 1; iaddr = 32'h0000_0040; ramstate = 2'd1;
    #1;
    checks++;
    if (ramREN !== 1'b0) begin
      errors++; $display("FAIL ird_idle_ren got %0b exp 0", ramREN);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
        errors++; $display("FAIL ird_busy%0d got ren=%0b addr=%h iw=%0b exp 1 40 1", i, ramREN, ramaddr, iwait);
      end
      tick();
    end
    ramstate = 2'd2; ramload = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (iwait !== 1'b0 || iload !== 32'hDEAD_BEEF || dwait !== 1'b1) begin
      errors++; $display("FAIL ird_access got iw=%0b il=%h dw=%0b exp 0 deadbeef 1", iwait, iload, dwait);
    end
    tick();
    iREN = 0; ramstate = 2'd0;
    #1;
    checks++;
    if (st !== 2'd0 || iwait !== 1'b1 || iload !== 32'd0) begin
      errors++; $display("FAIL ird_after got st=%0d iw=%0b il=%h exp 0 1 0", st, iwait, iload);
    end
  endtask

  task automatic test_simultaneous();
    iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'h1234_5678; ramstate = 2'd1;
    tick();
    checks++;
    if (st !== 2'd2 || ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'h1234_5678) begin
      errors++; $display("FAIL sim_dgnt got st=%0d wen=%0b ren=%0b addr=%h store=%h exp 2 1 0 100 12345678", st, ramWEN, ramREN, ramaddr, ramstore);
    end
    ramstate = 2'd2; ramload = 32'h5555_AAAA;
    #1;
    checks++;
    if (dwait !== 1'b0 || iwait !== 1'b1) begin
      errors++; $display("FAIL sim_dacc got dw=%0b iw=%0b exp 0 1", dwait, iwait);
    end
    tick();
    dWEN = 0; ramstate = 2'd1;
    #1;
    checks++;
    if (st !== 2'd0 || dst !== 3'd1) begin
      errors++; $display("FAIL sim_turn got st=%0d dst=%0d exp 0 1", st, dst);
    end
    tick();
    checks++;
    if (st !== 2'd1 || ramREN !== 1'b1 || ramaddr !== 32'h80 || ramstore !== 32'd0) begin
      errors++; $display("FAIL sim_ignt got st=%0d ren=%0b addr=%h store=%h exp 1 1 80 0", st, ramREN, ramaddr, ramstore);
    end
    ramstate = 2'd2; ramload = 32'h0BAD_F00D;
    #1;
    checks++;
    if (iwait !== 1'b0 || iload !== 32'h0BAD_F00D || dload !== 32'd0) begin
      errors++; $display("FAIL sim_iacc got iw=%0b il=%h dl=%h exp 0 0badf00d 0", iwait, iload, dload);
    end
    tick();
    iREN = 0; ramstate = 2'd0;
    #1;
    checks++;
    if (st !== 2'd0 || dst !== 3'd0) begin
      errors++; $display("FAIL sim_end got st=%0d dst=%0d exp 0 0", st, dst);
    end
  endtask

  task automatic test_starvation();
    int  dcnt;
    bit  idone;
    dcnt = 0; idone = 0;
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h300; ramstate = 2'd2; ramload = 32'h1111_2222;
    for (int c = 0; c < 40 && !idone; c++) begin
      #1;
      if (dwait === 1'b0) dcnt++;
      if (iwait === 1'b0) idone = 1;
      else tick();
    end
    checks++;
    if (!idone || dcnt != 4) begin
      errors++; $display("FAIL starve got idone=%0b dcnt=%0d exp 1 4", idone, dcnt);
    end
    tick();
    iREN = 0; dREN = 0; ramstate = 2'd0;
    #1;
    checks++;
    if (dst !== 3'd0 || st !== 2'd0) begin
      errors++; $display("FAIL starve_clr got dst=%0d st=%0d exp 0 0", dst, st);
    end
  endtask

  task automatic test_abort();
    dREN = 1; daddr = 32'h200; ramstate = 2'd1;
    tick();
    checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h200) begin
      errors++; $display("FAIL abort_grant got ren=%0b wen=%0b addr=%h exp 1 0 200", ramREN, ramWEN, ramaddr);
    end
    tick();
    dREN = 0;
    #1;
    checks++;
    if (ramREN !== 1'b0 || dwait !== 1'b1) begin
      errors++; $display("FAIL abort_drop got ren=%0b dw=%0b exp 0 1", ramREN, dwait);
    end
    tick();
    checks++;
    if (st !== 2'd0) begin
      errors++; $display("FAIL abort_idle got st=%0d exp 0", st);
    end
  endtask

  task automatic test_error();
    iREN = 1; iaddr = 32'h60; ramstate = 2'd1;
    tick();
    ramstate = 2'd3;
    #1;
    checks++;
    if (ram_err !== 1'b0 || iwait !== 1'b1) begin
      errors++; $display("FAIL err_pre got err=%0b iw=%0b exp 0 1", ram_err, iwait);
    end
    tick();
    ramstate = 2'd2; ramload = 32'hCAFE_F00D;
    #1;
    checks++;
    if (ram_err !== 1'b1 || iwait !== 1'b0 || iload !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL err_acc got err=%0b iw=%0b il=%h exp 1 0 cafef00d", ram_err, iwait, iload);
    end
    tick();
    iREN = 0; ramstate = 2'd0;
    tick();
    checks++;
    if (ram_err !== 1'b1 || st !== 2'd0) begin
      errors++; $display("FAIL err_sticky got err=%0b st=%0d exp 1 0", ram_err, st);
    end
  endtask

  task automatic test_reset_mid();
    iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
    tick();
    checks++;
    if (ramREN !== 1'b1) begin
      errors++; $display("FAIL rmid_pre got ren=%0b exp 1", ramREN);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1 || ram_err !== 1'b0 || st !== 2'd0) begin
      errors++; $display("FAIL rmid_async got ren=%0b iw=%0b err=%0b st=%0d exp 0 1 0 0", ramREN, iwait, ram_err, st);
    end
    @(negedge CLK);
    nRST = 1'b1; iREN = 0; ramstate = 2'd0;
    tick();
    checks++;
    if (st !== 2'd0 || ramREN !== 1'b0) begin
      errors++; $display("FAIL rmid_after got st=%0d ren=%0b exp 0 0", st, ramREN);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_icache_read();
    test_simultaneous();
    test_starvation();
    test_abort();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
